// File: rtl/descriptor_packetizer_if.sv
// Stream port bundle for the descriptor packetizer: 32-bit data, valid/ready handshake
// and a last marker on the trailer word.
interface descriptor_packetizer_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/descriptor_packetizer.sv
// Queues BRIEF descriptors and frame markers, then serializes them as 9-word packets
// (header + 8 data words) and 1-word trailers carrying the per-frame descriptor count.
//
// state | meaning
// IDLE  | nothing presented on the stream
// HDR   | header word of a descriptor packet presented
// DATA  | descriptor word `beat` (0..7) presented
// TRL   | frame trailer presented (tlast=1)
module descriptor_packetizer #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [7:0]  HDR_TAG    = 8'hD5,
  parameter logic [7:0]  TRL_TAG    = 8'hE0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [255:0]                  descriptor,
  input  logic                          descriptor_valid,
  input  logic [10:0]                   descriptor_x,
  input  logic [10:0]                   descriptor_y,
  input  logic                          frame_start,
  descriptor_packetizer_if.master       m_axis,
  output logic [15:0]                   drop_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = 1 + 11 + 11 + 256;
  localparam logic [AW:0] LVL_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, HDR, DATA, TRL} state_t;

  logic [EW-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             fifo_full, fifo_empty, room;
  logic             push, pop, desc_push, marker_push, drop;
  logic             marker_pending;
  logic [EW-1:0]    push_entry, head;
  logic             head_marker;
  logic [10:0]      head_x, head_y;
  logic [255:0]     head_desc;

  state_t           state, state_nxt;
  logic [2:0]       beat, beat_nxt;
  logic [7:0][31:0] cur_words;
  logic [15:0]      frame_count;
  logic [31:0]      tdata_q, tdata_nxt;
  logic             tvalid_q, tvalid_nxt, tlast_q, tlast_nxt;
  logic             hdr_accept, trl_accept, last_word;

  assign fifo_full   = (fifo_level == LVL_FULL);
  assign fifo_empty  = (fifo_level == '0);
  // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
  assign room        = !fifo_full || pop;
  assign desc_push   = descriptor_valid && room && !marker_pending;
  assign marker_push = marker_pending && room && !descriptor_valid;
  assign push        = desc_push || marker_push;
  assign drop        = descriptor_valid && !desc_push;
  assign push_entry  = marker_push ? {1'b1, {(EW-1){1'b0}}}
                                   : {1'b0, descriptor_x, descriptor_y, descriptor};

  assign head        = mem[rd_ptr];
  assign head_marker = head[EW-1];
  assign head_x      = head[EW-2 -: 11];
  assign head_y      = head[EW-13 -: 11];
  assign head_desc   = head[255:0];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_level     <= '0;
      marker_pending <= 1'b0;
      drop_count     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_ONE;
        2'b01:   fifo_level <= fifo_level - LVL_ONE;
        default: fifo_level <= fifo_level;
      endcase
      // A frame_start arriving while a marker is already owed folds into that marker.
      if (marker_push)      marker_pending <= 1'b0;
      else if (frame_start) marker_pending <= 1'b1;
      if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      beat        <= '0;
      cur_words   <= '0;
      frame_count <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
    end else begin
      state    <= state_nxt;
      beat     <= beat_nxt;
      tdata_q  <= tdata_nxt;
      tvalid_q <= tvalid_nxt;
      tlast_q  <= tlast_nxt;
      if (pop) cur_words <= head_desc;
      if (trl_accept)                                frame_count <= '0;
      else if (hdr_accept && frame_count != 16'hFFFF) frame_count <= frame_count + 16'd1;
    end
  end

  // A new packet starts only when downstream is ready, so stalled traffic stays in the FIFO.
  assign last_word  = (state == IDLE) || (state == TRL) || (state == DATA && beat == 3'd7);
  assign pop        = last_word && m_axis.tready && !fifo_empty;
  assign hdr_accept = (state == HDR) && m_axis.tready;
  assign trl_accept = (state == TRL) && m_axis.tready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop) state_nxt = head_marker ? TRL : HDR;
      HDR:     if (m_axis.tready) state_nxt = DATA;
      DATA,
      TRL:     if (m_axis.tready && last_word)
                 state_nxt = fifo_empty ? IDLE : (head_marker ? TRL : HDR);
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    beat_nxt   = beat;
    tdata_nxt  = tdata_q;
    tvalid_nxt = tvalid_q;
    tlast_nxt  = tlast_q;
    if (pop) begin
      tvalid_nxt = 1'b1;
      tlast_nxt  = head_marker;
      tdata_nxt  = head_marker ? {TRL_TAG, 8'h00, (state == TRL) ? 16'd0 : frame_count}
                               : {HDR_TAG, 1'b0, head_y, 1'b0, head_x};
    end else if (hdr_accept) begin
      beat_nxt  = 3'd0;
      tdata_nxt = cur_words[0];
      tlast_nxt = 1'b0;
    end else if (state == DATA && m_axis.tready && beat != 3'd7) begin
      beat_nxt  = beat + 3'd1;
      tdata_nxt = cur_words[beat + 3'd1];
    end else if (state != IDLE && m_axis.tready) begin
      tvalid_nxt = 1'b0;
      tlast_nxt  = 1'b0;
      tdata_nxt  = '0;
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
endmodule

// File: tb/tb_descriptor_packetizer.sv
// Directed bench for descriptor_packetizer: latency, framing, overflow, backpressure and reset.
module tb_descriptor_packetizer;
  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] descriptor;
  logic         descriptor_valid;
  logic [10:0]  descriptor_x, descriptor_y;
  logic         frame_start;
  logic [15:0]  drop_count;
  logic [4:0]   fifo_level;

  descriptor_packetizer_if m_axis();

  descriptor_packetizer #(.FIFO_DEPTH(16), .HDR_TAG(8'hD5), .TRL_TAG(8'hE0)) dut (
    .clk(clk), .rst(rst), .descriptor(descriptor), .descriptor_valid(descriptor_valid),
    .descriptor_x(descriptor_x), .descriptor_y(descriptor_y), .frame_start(frame_start),
    .m_axis(m_axis), .drop_count(drop_count), .fifo_level(fifo_level));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic        exp_last_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    descriptor_valid = 1'b0;
    frame_start      = 1'b0;
    descriptor       = '0;
    descriptor_x     = '0;
    descriptor_y     = '0;
  endtask

  task automatic send(input logic [10:0] x, input logic [10:0] y, input logic [255:0] d);
    descriptor_valid = 1'b1;
    descriptor_x     = x;
    descriptor_y     = y;
    descriptor       = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [255:0] mk_desc(input int seed);
    logic [255:0] d;
    d = '0;
    for (int k = 0; k < 8; k++) d[k*32 +: 32] = {8'(seed), 8'(k), 16'(seed * 37 + k * 11)};
    return d;
  endfunction

  task automatic push_pkt(input logic [10:0] x, input logic [10:0] y, input logic [255:0] d);
    exp_q.push_back({8'hD5, 1'b0, y, 1'b0, x});
    exp_last_q.push_back(1'b0);
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(d[k*32 +: 32]);
      exp_last_q.push_back(1'b0);
    end
  endtask

  task automatic push_trl(input logic [15:0] n);
    exp_q.push_back({8'hE0, 8'h00, n});
    exp_last_q.push_back(1'b1);
  endtask

  // Expects the next queued word on the stream this cycle, then advances one clock.
  task automatic check_word(input string tag);
    logic [31:0] ed;
    logic        el;
    ed = exp_q.pop_front();
    el = exp_last_q.pop_front();
    chk({tag, "_valid"}, 32'(m_axis.tvalid), 32'd1);
    chk({tag, "_data"}, m_axis.tdata, ed);
    chk({tag, "_last"}, 32'(m_axis.tlast), 32'(el));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] df;
    logic         held_valid;
    logic [31:0]  held_data;
    logic         held_last;

    m_axis.tready = 1'b0;
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    chk("rst_tvalid", 32'(m_axis.tvalid), 32'd0);
    chk("rst_tlast", 32'(m_axis.tlast), 32'd0);
    chk("rst_tdata", m_axis.tdata, 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_drops", 32'(drop_count), 32'd0);
    rst = 1'b0;

    // single descriptor, header two cycles after the push
    m_axis.tready = 1'b1;
    send(11'd5, 11'd3, 256'h1);
    tick();
    idle_inputs();
    chk("t1_c1_tvalid", 32'(m_axis.tvalid), 32'd0);
    tick();
    chk("t1_hdr_const", m_axis.tdata, 32'hD5003005);
    push_pkt(11'd5, 11'd3, 256'h1);
    for (int i = 0; i < 9; i++) check_word("t1_word");
    chk("t1_end_tvalid", 32'(m_axis.tvalid), 32'd0);

    // two descriptors + frame_start: 18 contiguous words then trailer with count 2
    do_reset();
    m_axis.tready = 1'b1;
    send(11'd10, 11'd20, mk_desc(1));
    tick();
    send(11'd11, 11'd21, mk_desc(2));
    tick();
    idle_inputs();
    frame_start = 1'b1;
    push_pkt(11'd10, 11'd20, mk_desc(1));
    push_pkt(11'd11, 11'd21, mk_desc(2));
    push_trl(16'd2);
    check_word("t2_word");
    frame_start = 1'b0;
    for (int i = 0; i < 18; i++) check_word("t2_word");
    chk("t2_end_tvalid", 32'(m_axis.tvalid), 32'd0);
    // frame count restarted: next frame of one descriptor reports 1
    send(11'd1, 11'd2, mk_desc(3));
    tick();
    idle_inputs();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    push_pkt(11'd1, 11'd2, mk_desc(3));
    push_trl(16'd1);
    for (int i = 0; i < 10; i++) check_word("t2b_word");

    // overflow with downstream stalled
    do_reset();
    m_axis.tready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      send(11'(i), 11'(i + 100), mk_desc(i + 50));
      tick();
    end
    idle_inputs();
    tick();
    chk("t3_level_full", 32'(fifo_level), 32'd16);
    chk("t3_drops", 32'(drop_count), 32'd1);
    chk("t3_stalled_tvalid", 32'(m_axis.tvalid), 32'd0);
    for (int i = 0; i < 16; i++) push_pkt(11'(i), 11'(i + 100), mk_desc(i + 50));
    m_axis.tready = 1'b1;
    tick();
    for (int i = 0; i < 144; i++) check_word("t3_word");
    for (int i = 0; i < 4; i++) begin
      chk("t3_after_tvalid", 32'(m_axis.tvalid), 32'd0);
      tick();
    end
    chk("t3_after_level", 32'(fifo_level), 32'd0);

    // random backpressure: order and stall stability
    do_reset();
    push_pkt(11'd100, 11'd200, mk_desc(7));
    push_pkt(11'd101, 11'd201, mk_desc(8));
    push_pkt(11'd102, 11'd202, mk_desc(9));
    push_trl(16'd3);
    push_pkt(11'd2047, 11'd2047, mk_desc(10));
    push_trl(16'd1);
    held_valid = 1'b0;
    held_data  = '0;
    held_last  = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      idle_inputs();
      case (cyc)
        0: send(11'd100, 11'd200, mk_desc(7));
        2: send(11'd101, 11'd201, mk_desc(8));
        3: send(11'd102, 11'd202, mk_desc(9));
        5: frame_start = 1'b1;
        8: send(11'd2047, 11'd2047, mk_desc(10));
        9: frame_start = 1'b1;
        default: ;
      endcase
      m_axis.tready = 1'($urandom_range(0, 1));
      if (held_valid) begin
        chk("t4_hold_valid", 32'(m_axis.tvalid), 32'd1);
        chk("t4_hold_data", m_axis.tdata, held_data);
        chk("t4_hold_last", 32'(m_axis.tlast), 32'(held_last));
      end
      if (m_axis.tvalid && m_axis.tready && exp_q.size() > 0) begin
        chk("t4_data", m_axis.tdata, exp_q.pop_front());
        chk("t4_last", 32'(m_axis.tlast), 32'(exp_last_q.pop_front()));
      end
      held_valid = m_axis.tvalid && !m_axis.tready;
      held_data  = m_axis.tdata;
      held_last  = m_axis.tlast;
      tick();
      if (cyc > 12 && exp_q.size() == 0) break;
    end
    idle_inputs();
    chk("t4_remaining", 32'(exp_q.size()), 32'd0);
    m_axis.tready = 1'b1;
    tick();
    tick();
    chk("t4_end_tvalid", 32'(m_axis.tvalid), 32'd0);

    // descriptor and frame_start together, then a descriptor that must be dropped
    do_reset();
    m_axis.tready = 1'b1;
    send(11'd7, 11'd8, mk_desc(20));
    frame_start = 1'b1;
    tick();
    send(11'd9, 11'd9, mk_desc(21));
    frame_start = 1'b0;
    tick();
    idle_inputs();
    push_pkt(11'd7, 11'd8, mk_desc(20));
    push_trl(16'd1);
    for (int i = 0; i < 10; i++) check_word("t5_word");
    chk("t5_drops", 32'(drop_count), 32'd1);
    chk("t5_end_tvalid", 32'(m_axis.tvalid), 32'd0);

    // reset on DATA beat 4 with two packets still queued
    df = mk_desc(30);
    send(11'd3, 11'd4, df);
    tick();
    send(11'd6, 11'd6, mk_desc(31));
    tick();
    send(11'd7, 11'd7, mk_desc(32));
    chk("t6_hdr", m_axis.tdata, {8'hD5, 1'b0, 11'd4, 1'b0, 11'd3});
    tick();
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      chk("t6_beat", m_axis.tdata, df[k*32 +: 32]);
      tick();
    end
    chk("t6_beat4", m_axis.tdata, df[4*32 +: 32]);
    chk("t6_level_before", 32'(fifo_level), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_tvalid", 32'(m_axis.tvalid), 32'd0);
    chk("t6_rst_level", 32'(fifo_level), 32'd0);
    chk("t6_rst_drops", 32'(drop_count), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_resume", 32'(m_axis.tvalid), 32'd0);
    end
    send(11'd12, 11'd13, mk_desc(33));
    tick();
    idle_inputs();
    tick();
    push_pkt(11'd12, 11'd13, mk_desc(33));
    for (int i = 0; i < 9; i++) check_word("t6_fresh");
    chk("t6_end_tvalid", 32'(m_axis.tvalid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
